tdc_frame_sequencer: RTL and testbench

// - Producer side of the histogram-builder input stream (wrEn/data).
// - Collects per-acquisition TDC hits tagged with a pixel index into a slot buffer.
// - Replays the hits in the builder's fixed order: pixel 0..PIXEL_NUM-1, DATA_NUM slots
//   per pixel, one word per cycle.
// - Repeats for ACQ_NUM acquisitions per pass and two passes per frame (coarse, then fine).

---
 rtl/tdc_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_tdc_frame_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_frame_sequencer.sv
// tdc_frame_sequencer
// Collects TDC hits tagged with a pixel index into a slot buffer during one
// acquisition, then replays every slot in the histogram builder's fixed order
// (pixel 0..PIXEL_NUM-1, DATA_NUM slots per pixel, one word per cycle).
// Acquisitions repeat ACQ_NUM times per pass. Each frame is two passes: a
// coarse pass followed by a fine pass, with a GAP_CYC idle stretch after each.
//
// Ports
//   clk         rising-edge clock
//   res         asynchronous reset, active low
//   start       one-cycle pulse that begins a frame from IDLE
//   in_valid    hit present on in_pixel/in_data
//   in_ready    hit accepted when in_valid & in_ready
//   in_pixel    pixel index of the hit
//   in_data     hit timestamp (all-ones is reserved for "empty slot")
//   in_acq_end  closes collection for the current acquisition
//   wrEn        output word valid, drives the builder's wrEn
//   data        output word; all-ones marks an empty slot
//   pass        0 = coarse pass, 1 = fine pass
//   acq_idx     acquisition being collected or emitted
//   busy        high from accepted start until frame_done
//   frame_done  one-cycle pulse at the end of the frame
//   drop_count  hits dropped in this frame, saturating
module tdc_frame_sequencer #(
   parameter int NP        = 12,
   parameter int DATA_NUM  = 2,
   parameter int PIXEL_NUM = 200,
   parameter int ACQ_NUM   = 33333,
   parameter int PIX_W     = 8,
   parameter int ACQ_W     = 20,
   parameter int GAP_CYC   = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic [NP-1:0]    in_data,
   input  logic             in_acq_end,
   output logic             wrEn,
   output logic [NP-1:0]    data,
   output logic             pass,
   output logic [ACQ_W-1:0] acq_idx,
   output logic             busy,
   output logic             frame_done,
   output logic [15:0]      drop_count
);

   localparam int SLOTS = PIXEL_NUM * DATA_NUM;
   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int CNT_W = $clog2(SLOTS + 1);
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      EMIT,
      GAP,
      DONE
   } state_t;

   state_t           state;
   logic [NP-1:0]    slot_mem [SLOTS];
   logic [SLOTS-1:0] slot_valid;
   logic [CNT_W-1:0] emit_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic             hit_acc;
   logic             end_acc;
   logic             pixel_ok;
   logic             data_ok;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] cand;
   logic             write_en;
   logic             drop;
   logic [IDX_W-1:0] emit_idx;

   // in_ready is a registered copy of "state is COLLECT", so acceptance
   // qualifiers are simple ANDs with it.
   assign hit_acc  = in_valid & in_ready;
   assign end_acc  = in_acq_end & in_ready;
   assign pixel_ok = (32'(in_pixel) < 32'(PIXEL_NUM));
   assign data_ok  = (in_data != '1);
   assign emit_idx = IDX_W'(emit_cnt);

   // Slots are laid out pixel-major (pixel*DATA_NUM + slot), so the emit
   // order is simply increasing slot address. Filling the lowest free slot of
   // a pixel keeps its hits in arrival order.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      cand       = '0;
      if (pixel_ok) begin
         for (int s = 0; s < DATA_NUM; s++) begin
            cand = IDX_W'(int'(in_pixel) * DATA_NUM + s);
            if (!free_found && !slot_valid[cand]) begin
               free_found = 1'b1;
               free_idx   = cand;
            end
         end
      end
   end

   assign write_en = hit_acc & pixel_ok & data_ok & free_found;
   assign drop     = hit_acc & ~write_en;

   // Timestamp storage carries no reset; slot_valid alone decides whether a
   // stored word is meaningful.
   always_ff @(posedge clk) begin
      if (write_en) begin
         slot_mem[free_idx] <= in_data;
      end
   end

   // Frame sequencer. Every transition into COLLECT clears all valid bits so
   // the first collect cycle already sees an empty buffer.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         wrEn       <= 1'b0;
         data       <= '1;
         pass       <= 1'b0;
         acq_idx    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         drop_count <= '0;
         slot_valid <= '0;
         emit_cnt   <= '0;
         gap_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;

         if (write_en) begin
            slot_valid[free_idx] <= 1'b1;
         end
         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end

         case (state)
            IDLE: begin
               in_ready <= 1'b0;
               if (start) begin
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  acq_idx    <= '0;
                  drop_count <= '0;
                  slot_valid <= '0;
                  in_ready   <= 1'b1;
                  state      <= COLLECT;
               end
            end

            COLLECT: begin
               // A hit arriving with in_acq_end is stored by the write logic
               // above on this same edge, so it lands in this acquisition.
               if (end_acc) begin
                  in_ready <= 1'b0;
                  emit_cnt <= '0;
                  state    <= EMIT;
               end
            end

            EMIT: begin
               if (emit_cnt != CNT_W'(SLOTS)) begin
                  wrEn     <= 1'b1;
                  data     <= slot_valid[emit_idx] ? slot_mem[emit_idx] : '1;
                  emit_cnt <= emit_cnt + 1'b1;
               end else begin
                  wrEn <= 1'b0;
                  data <= '1;
                  if (acq_idx != ACQ_W'(ACQ_NUM - 1)) begin
                     acq_idx    <= acq_idx + 1'b1;
                     slot_valid <= '0;
                     in_ready   <= 1'b1;
                     state      <= COLLECT;
                  end else begin
                     acq_idx <= '0;
                     gap_cnt <= '0;
                     state   <= GAP;
                  end
               end
            end

            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                  if (!pass) begin
                     pass       <= 1'b1;
                     slot_valid <= '0;
                     in_ready   <= 1'b1;
                     state      <= COLLECT;
                  end else begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     pass       <= 1'b0;
                     state      <= DONE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_frame_sequencer.sv
// Directed testbench for tdc_frame_sequencer with a small frame
// (4 pixels, 2 slots, 2 acquisitions per pass, 4 gap cycles).
// A per-acquisition hit model builds the expected burst contents and tags;
// a compare process checks every output word plus burst timing.
module tb_tdc_frame_sequencer;

   localparam int NP    = 12;
   localparam int D     = 2;
   localparam int P     = 4;
   localparam int A     = 2;
   localparam int PIX_W = 8;
   localparam int ACQ_W = 20;
   localparam int GAP   = 4;
   localparam int NW    = P * D;

   logic             clk = 1'b0;
   logic             res = 1'b0;
   logic             start = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [PIX_W-1:0] in_pixel = '0;
   logic [NP-1:0]    in_data = '0;
   logic             in_acq_end = 1'b0;
   logic             wrEn;
   logic [NP-1:0]    data;
   logic             pass;
   logic [ACQ_W-1:0] acq_idx;
   logic             busy;
   logic             frame_done;
   logic [15:0]      drop_count;

   tdc_frame_sequencer #(
      .NP(NP), .DATA_NUM(D), .PIXEL_NUM(P), .ACQ_NUM(A),
      .PIX_W(PIX_W), .ACQ_W(ACQ_W), .GAP_CYC(GAP)
   ) dut (
      .clk(clk), .res(res), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
      .in_data(in_data), .in_acq_end(in_acq_end),
      .wrEn(wrEn), .data(data), .pass(pass), .acq_idx(acq_idx),
      .busy(busy), .frame_done(frame_done), .drop_count(drop_count)
   );

   initial forever #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int doneCount = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Expected output stream and the acquisition-end cycles it came from.
   logic [NP-1:0] expData[$];
   bit            expPass[$];
   int            expAcq[$];
   int            endCycQ[$];

   // Hits gathered in the current acquisition, per pixel in arrival order.
   logic [NP-1:0] hv[P][D];
   int            cnt[P];
   int            modelDrops = 0;
   int            acqModel = 0;
   bit            passModel = 1'b0;

   logic [NP-1:0] capWords[NW];

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic modelStart();
      modelDrops = 0;
      acqModel   = 0;
      passModel  = 1'b0;
      for (int p = 0; p < P; p++) cnt[p] = 0;
   endtask

   task automatic modelHit(input int p, input int d);
      if (p >= P || d == 'hFFF || cnt[p] >= D) begin
         modelDrops++;
      end else begin
         hv[p][cnt[p]] = NP'(d);
         cnt[p]++;
      end
   endtask

   task automatic modelEnd();
      for (int p = 0; p < P; p++) begin
         for (int s = 0; s < D; s++) begin
            expData.push_back((s < cnt[p]) ? hv[p][s] : 12'hFFF);
            expPass.push_back(passModel);
            expAcq.push_back(acqModel);
         end
         cnt[p] = 0;
      end
      endCycQ.push_back(cyc);
      acqModel++;
      if (acqModel == A) begin
         acqModel  = 0;
         passModel = !passModel;
      end
   endtask

   // Waits for in_ready, presents one input beat for one cycle and updates
   // the model. Called on a falling edge.
   task automatic applyStimulus(input bit valid, input int p, input int d, input bit endAcq);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checkOutput("ready_timeout", 0, 1);
         return;
      end
      in_valid   = valid;
      in_pixel   = PIX_W'(p);
      in_data    = NP'(d);
      in_acq_end = endAcq;
      if (valid) modelHit(p, d);
      if (endAcq) modelEnd();
      @(negedge clk);
      in_valid   = 1'b0;
      in_acq_end = 1'b0;
      if (endAcq) checkOutput("ready_fall", int'(in_ready), 0);
   endtask

   task automatic startFrame();
      start = 1'b1;
      modelStart();
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_set", int'(busy), 1);
      checkOutput("drop_clear", int'(drop_count), 0);
   endtask

   task automatic waitBurst();
      int n = 0;
      while ((expData.size() != 0 || wrEn) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("burst_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic waitFrameDone(input int target);
      int n = 0;
      while (doneCount < target && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (doneCount < target) checkOutput("done_timeout", doneCount, target);
      @(negedge clk);
   endtask

   // Compare process: every wrEn word against the model, plus burst
   // latency/length and the idle spacing after each burst.
   initial begin : compareProc
      bit            inBurst = 1'b0;
      bit            pending = 1'b0;
      bit            prevReady = 1'b0;
      bit            lastPass = 1'b0;
      int            lastAcq = 0;
      int            burstLen = 0;
      int            lastWrCyc = 0;
      logic [NP-1:0] ed;
      forever begin
         @(negedge clk);
         if (!res) begin
            inBurst   = 1'b0;
            pending   = 1'b0;
            prevReady = 1'b0;
            burstLen  = 0;
         end else begin
            if (wrEn) begin
               if (!inBurst) begin
                  inBurst  = 1'b1;
                  burstLen = 0;
                  if (endCycQ.size() == 0) checkOutput("latency_noend", 0, 1);
                  else checkOutput("latency", cyc - endCycQ.pop_front(), 2);
               end
               if (expData.size() == 0) begin
                  checkOutput("unexpected_wrEn", 1, 0);
               end else begin
                  ed       = expData.pop_front();
                  lastPass = expPass.pop_front();
                  lastAcq  = expAcq.pop_front();
                  checkOutput("data", int'(data), int'(ed));
                  checkOutput("pass", int'(pass), int'(lastPass));
                  checkOutput("acq_idx", int'(acq_idx), lastAcq);
               end
               if (burstLen < NW) capWords[burstLen] = data;
               burstLen++;
               lastWrCyc = cyc;
            end else if (inBurst) begin
               inBurst = 1'b0;
               checkOutput("burst_len", burstLen, NW);
               pending = !(lastPass && lastAcq == A - 1);
            end
            if (in_ready && !prevReady && pending) begin
               checkOutput("ready_gap", cyc - lastWrCyc, (lastAcq == A - 1) ? GAP + 1 : 1);
               pending = 1'b0;
            end
            if (frame_done) begin
               doneCount++;
               checkOutput("done_gap", cyc - lastWrCyc, GAP + 1);
               checkOutput("done_lastpass", int'(lastPass), 1);
            end
            prevReady = in_ready;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : stim
      logic [NP-1:0] lit0[NW];
      lit0 = '{12'h100, 12'h200, 12'hFFF, 12'hFFF, 12'h050, 12'hFFF, 12'hFFF, 12'hFFF};

      repeat (3) @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      checkOutput("rst_in_ready", int'(in_ready), 0);
      checkOutput("rst_wrEn", int'(wrEn), 0);
      checkOutput("rst_data", int'(data), 'hFFF);
      checkOutput("rst_pass", int'(pass), 0);
      checkOutput("rst_acq_idx", int'(acq_idx), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_frame_done", int'(frame_done), 0);
      checkOutput("rst_drop_count", int'(drop_count), 0);

      // Frame 1, pass 0, acquisition 0: basic ordering and empty slots.
      startFrame();
      applyStimulus(1, 0, 'h100, 0);
      applyStimulus(1, 0, 'h200, 0);
      applyStimulus(1, 2, 'h050, 0);
      applyStimulus(0, 0, 0, 1);
      waitBurst();
      for (int k = 0; k < NW; k++) checkOutput("lit_burst0", int'(capWords[k]), int'(lit0[k]));
      checkOutput("drop_acq0", int'(drop_count), 0);

      // Acquisition 1: full pixel, out-of-range pixel, reserved timestamp,
      // and a hit sharing the cycle with in_acq_end.
      applyStimulus(1, 1, 'h011, 0);
      applyStimulus(1, 1, 'h022, 0);
      applyStimulus(1, 1, 'h033, 0);
      applyStimulus(1, 7, 'h123, 0);
      applyStimulus(1, 3, 'hFFF, 0);
      applyStimulus(1, 3, 'h0AB, 1);
      waitBurst();
      checkOutput("lit_p1s0", int'(capWords[2]), 'h011);
      checkOutput("lit_p1s1", int'(capWords[3]), 'h022);
      checkOutput("lit_p3s0", int'(capWords[6]), 'h0AB);
      checkOutput("lit_p3s1", int'(capWords[7]), 'hFFF);
      checkOutput("drop_acq1", int'(drop_count), 3);

      // Pass 1; a start pulse mid-frame must be ignored.
      applyStimulus(1, 3, 'h7FE, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      applyStimulus(1, 0, 'h001, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      waitFrameDone(1);
      checkOutput("busy_clear", int'(busy), 0);
      checkOutput("drop_final", int'(drop_count), 3);
      checkOutput("done_count1", doneCount, 1);

      // Frame 2: asynchronous reset in the middle of a burst.
      startFrame();
      applyStimulus(1, 1, 'h5A5, 0);
      applyStimulus(0, 0, 0, 1);
      begin
         int n = 0;
         while (!wrEn && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!wrEn) checkOutput("emit_timeout", 0, 1);
      end
      @(negedge clk);
      @(posedge clk);
      #2 res = 1'b0;
      #1;
      checkOutput("abort_wrEn", int'(wrEn), 0);
      checkOutput("abort_data", int'(data), 'hFFF);
      checkOutput("abort_in_ready", int'(in_ready), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_pass", int'(pass), 0);
      checkOutput("abort_acq_idx", int'(acq_idx), 0);
      expData.delete();
      expPass.delete();
      expAcq.delete();
      endCycQ.delete();
      repeat (3) @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_ready", int'(in_ready), 0);

      // Frame 3: clean full frame after the abort.
      startFrame();
      applyStimulus(1, 2, 'h321, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 'hABC, 1);
      applyStimulus(0, 0, 0, 1);
      waitFrameDone(2);
      checkOutput("busy_clear2", int'(busy), 0);
      checkOutput("done_count2", doneCount, 2);
      checkOutput("queue_empty", expData.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
